cpsr_cond_unit: RTL and testbench



---
 rtl/cpsr_pkg.sv | 32 +++
 rtl/cond_eval.sv | 40 ++++
 rtl/cpsr_cond_unit.sv | 135 +++++++++++++
 tb/tb_cpsr_cond_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpsr_pkg.sv
// rtl/cpsr_pkg.sv - shared condition-code, flag-index and FSM-state definitions
package cpsr_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluator, shared with the branch unit
module cond_eval
   import cpsr_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLG_N];
   assign z = nzcv[FLG_Z];
   assign c = nzcv[FLG_C];
   assign v = nzcv[FLG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpsr_cond_unit.sv
// rtl/cpsr_cond_unit.sv - NZCV status register, pending-op tracker and condition evaluation FSM
module cpsr_cond_unit
   import cpsr_pkg::*;
#(
   parameter int MAX_PEND = 3,
   parameter int PEND_W   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flag_we,
   input  logic [3:0] wr_mask,
   input  logic       in_n,
   input  logic       in_z,
   input  logic       in_c,
   input  logic       in_v,
   input  logic       iss_valid,
   output logic       iss_ready,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] cond,
   output logic       rsp_valid,
   output logic       cond_pass,
   output logic       carry_out,
   output logic [3:0] nzcv
);

   logic [3:0]        nzcv_q;
   logic [3:0]        new_flags;
   logic [3:0]        eff_flags;
   logic [PEND_W-1:0] pend_cnt;
   logic              iss_fire;
   logic              flags_ready;
   state_t            state, state_n;
   logic [3:0]        cond_q;
   logic [3:0]        cond_sel;
   logic              cond_ld;
   logic              eval_en;
   logic              eval_pass;
   logic              pass_q;

   // Bypass: an in-cycle flag write is visible to the evaluator before it lands in nzcv_q.
   assign new_flags = (wr_mask & {in_n, in_z, in_c, in_v}) | (~wr_mask & nzcv_q);
   assign eff_flags = flag_we ? new_flags : nzcv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nzcv_q <= 4'b0000;
      end else if (flag_we) begin
         nzcv_q <= new_flags;
      end
   end

   assign nzcv      = nzcv_q;
   assign carry_out = nzcv_q[FLG_C];

   assign iss_ready = (pend_cnt < PEND_W'(MAX_PEND));
   assign iss_fire  = iss_valid && iss_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_cnt <= '0;
      end else if (iss_fire && !flag_we) begin
         pend_cnt <= pend_cnt + PEND_W'(1);
      end else if (!iss_fire && flag_we && (pend_cnt != '0)) begin
         pend_cnt <= pend_cnt - PEND_W'(1);
      end
   end

   // Uses pend_cnt before this cycle's increment, so a same-cycle issue never stalls the request.
   assign flags_ready = (pend_cnt == '0) || ((pend_cnt == PEND_W'(1)) && flag_we);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      cond_sel  = cond_q;
      cond_ld   = 1'b0;
      eval_en   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            cond_sel  = cond;
            if (req_valid) begin
               cond_ld = 1'b1;
               if (flags_ready) begin
                  eval_en = 1'b1;
                  state_n = RESP;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (flags_ready) begin
               eval_en = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   cond_eval u_cond_eval (
      .cond (cond_sel),
      .nzcv (eff_flags),
      .pass (eval_pass)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cond_q <= 4'h0;
         pass_q <= 1'b0;
      end else begin
         if (cond_ld) begin
            cond_q <= cond;
         end
         pass_q <= eval_en && eval_pass;
      end
   end

   assign cond_pass = pass_q;

endmodule

// File: tb/tb_cpsr_cond_unit.sv
// tb/tb_cpsr_cond_unit.sv - directed self-checking bench for cpsr_cond_unit
module tb_cpsr_cond_unit;

   logic       clk;
   logic       rst_n;
   logic       flag_we;
   logic [3:0] wr_mask;
   logic       in_n, in_z, in_c, in_v;
   logic       iss_valid;
   logic       iss_ready;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] cond;
   logic       rsp_valid;
   logic       cond_pass;
   logic       carry_out;
   logic [3:0] nzcv;

   int checks = 0;
   int errors = 0;

   cpsr_cond_unit #(.MAX_PEND(3), .PEND_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flag_we   (flag_we),
      .wr_mask   (wr_mask),
      .in_n      (in_n),
      .in_z      (in_z),
      .in_c      (in_c),
      .in_v      (in_v),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .cond      (cond),
      .rsp_valid (rsp_valid),
      .cond_pass (cond_pass),
      .carry_out (carry_out),
      .nzcv      (nzcv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] mask, input logic [3:0] f);
      flag_we = 1'b1;
      wr_mask = mask;
      {in_n, in_z, in_c, in_v} = f;
   endtask

   task automatic write_flags(input logic [3:0] mask, input logic [3:0] f);
      set_flags(mask, f);
      tick();
      flag_we = 1'b0;
   endtask

   task automatic do_req(input string tag, input logic [3:0] c, input logic exp);
      req_valid = 1'b1;
      cond      = c;
      tick();
      req_valid = 1'b0;
      check({tag, "_rsp"}, {7'd0, rsp_valid}, 8'd1);
      check({tag, "_pass"}, {7'd0, cond_pass}, {7'd0, exp});
      tick();
   endtask

   typedef struct {
      logic [3:0] flags;
      logic [3:0] c;
      logic       exp;
   } vec_t;

   vec_t vecs[20];

   initial begin
      vecs[0]  = '{4'b0000, 4'h1, 1'b1};
      vecs[1]  = '{4'b0000, 4'h3, 1'b1};
      vecs[2]  = '{4'b0000, 4'h8, 1'b0};
      vecs[3]  = '{4'b0000, 4'h9, 1'b1};
      vecs[4]  = '{4'b0000, 4'hC, 1'b1};
      vecs[5]  = '{4'b0000, 4'hF, 1'b0};
      vecs[6]  = '{4'b0110, 4'h8, 1'b0};
      vecs[7]  = '{4'b0110, 4'h9, 1'b1};
      vecs[8]  = '{4'b0110, 4'h2, 1'b1};
      vecs[9]  = '{4'b0110, 4'hD, 1'b1};
      vecs[10] = '{4'b1000, 4'h4, 1'b1};
      vecs[11] = '{4'b1000, 4'h5, 1'b0};
      vecs[12] = '{4'b1000, 4'hB, 1'b1};
      vecs[13] = '{4'b1000, 4'hA, 1'b0};
      vecs[14] = '{4'b1000, 4'hC, 1'b0};
      vecs[15] = '{4'b1000, 4'hE, 1'b1};
      vecs[16] = '{4'b0011, 4'h6, 1'b1};
      vecs[17] = '{4'b0011, 4'h7, 1'b0};
      vecs[18] = '{4'b0011, 4'h8, 1'b1};
      vecs[19] = '{4'b0011, 4'hB, 1'b1};

      rst_n     = 1'b0;
      flag_we   = 1'b0;
      wr_mask   = 4'h0;
      {in_n, in_z, in_c, in_v} = 4'h0;
      iss_valid = 1'b0;
      req_valid = 1'b0;
      cond      = 4'h0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      check("rst_nzcv", {4'd0, nzcv}, 8'h00);
      check("rst_carry", {7'd0, carry_out}, 8'd0);
      check("rst_iss_ready", {7'd0, iss_ready}, 8'd1);
      check("rst_req_ready", {7'd0, req_ready}, 8'd1);
      check("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);

      req_valid = 1'b1;
      cond      = 4'h0;
      tick();
      req_valid = 1'b0;
      check("eq_rsp", {7'd0, rsp_valid}, 8'd1);
      check("eq_pass", {7'd0, cond_pass}, 8'd0);
      check("eq_req_ready_resp", {7'd0, req_ready}, 8'd0);
      tick();
      check("eq_rsp_drop", {7'd0, rsp_valid}, 8'd0);
      check("eq_req_ready_idle", {7'd0, req_ready}, 8'd1);

      write_flags(4'b1111, 4'b1010);
      check("wr_full", {4'd0, nzcv}, 8'h0A);
      check("wr_full_carry", {7'd0, carry_out}, 8'd1);
      write_flags(4'b1100, 4'b0101);
      check("wr_masked", {4'd0, nzcv}, 8'h06);
      check("wr_masked_carry", {7'd0, carry_out}, 8'd1);

      write_flags(4'b0100, 4'b0000);
      check("clr_z", {4'd0, nzcv}, 8'h02);
      set_flags(4'b0100, 4'b0100);
      req_valid = 1'b1;
      cond      = 4'h0;
      tick();
      flag_we   = 1'b0;
      req_valid = 1'b0;
      check("bypass_rsp", {7'd0, rsp_valid}, 8'd1);
      check("bypass_pass", {7'd0, cond_pass}, 8'd1);
      check("bypass_nzcv", {4'd0, nzcv}, 8'h06);
      tick();

      iss_valid = 1'b1;
      tick();
      tick();
      iss_valid = 1'b0;
      req_valid = 1'b1;
      cond      = 4'hA;
      tick();
      req_valid = 1'b0;
      check("stall_wait_rsp", {7'd0, rsp_valid}, 8'd0);
      check("stall_wait_ready", {7'd0, req_ready}, 8'd0);
      tick();
      check("stall_hold_rsp", {7'd0, rsp_valid}, 8'd0);
      write_flags(4'b1001, 4'b1000);
      check("stall_first_we", {7'd0, rsp_valid}, 8'd0);
      check("stall_first_nzcv", {4'd0, nzcv}, 8'h0E);
      write_flags(4'b1001, 4'b1001);
      check("stall_second_rsp", {7'd0, rsp_valid}, 8'd1);
      check("stall_second_pass", {7'd0, cond_pass}, 8'd1);
      tick();
      check("stall_back_idle", {7'd0, req_ready}, 8'd1);
      check("stall_rsp_low", {7'd0, rsp_valid}, 8'd0);

      for (int i = 0; i < 20; i++) begin
         write_flags(4'b1111, vecs[i].flags);
         do_req($sformatf("vec%0d_c%0h", i, vecs[i].c), vecs[i].c, vecs[i].exp);
      end

      iss_valid = 1'b1;
      tick();
      tick();
      check("sat_two_ready", {7'd0, iss_ready}, 8'd1);
      tick();
      check("sat_three_ready", {7'd0, iss_ready}, 8'd0);
      tick();
      check("sat_fourth_ignored", {7'd0, iss_ready}, 8'd0);
      iss_valid = 1'b0;
      write_flags(4'b0000, 4'b0000);
      check("sat_retire_ready", {7'd0, iss_ready}, 8'd1);
      iss_valid = 1'b1;
      write_flags(4'b0000, 4'b0000);
      check("sat_both_ready", {7'd0, iss_ready}, 8'd1);
      tick();
      iss_valid = 1'b0;
      check("sat_both_held", {7'd0, iss_ready}, 8'd0);
      check("sat_nzcv_kept", {4'd0, nzcv}, 8'h03);

      req_valid = 1'b1;
      cond      = 4'hE;
      tick();
      req_valid = 1'b0;
      check("rstw_waiting", {7'd0, req_ready}, 8'd0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rstw_idle", {7'd0, req_ready}, 8'd1);
      check("rstw_no_rsp", {7'd0, rsp_valid}, 8'd0);
      check("rstw_nzcv", {4'd0, nzcv}, 8'h00);
      check("rstw_iss_ready", {7'd0, iss_ready}, 8'd1);
      tick();
      rst_n = 1'b1;
      tick();
      check("rstw_after_rsp", {7'd0, rsp_valid}, 8'd0);
      do_req("rstw_pend_zero", 4'hE, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
